// File: rtl/bt_cmd_frame_decoder.sv
// bt_cmd_frame_decoder: parses 55/CMD/ARG/CHK frames from uart_recv into mode, slot and status
//   sys_clk, sys_rst_n (sync, active-low); rx_done, rx_data[7:0] from uart_recv;
//   mode_onehot[MODE_NUM], slot_no[SLOT_W], cmd_valid/cmd_err pulses, err_cnt[7:0] saturating
module bt_cmd_frame_decoder #(
  parameter int SLOT_W      = 4,
  parameter int SLOT_NUM    = 16,
  parameter int MODE_NUM    = 4,
  parameter int RESET_MODE  = 3,
  parameter int WRAP        = 0,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  output logic [MODE_NUM-1:0] mode_onehot,
  output logic [SLOT_W-1:0]   slot_no,
  output logic                cmd_valid,
  output logic                cmd_err,
  output logic [7:0]          err_cnt
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_NUM - 1);
  localparam logic [MODE_NUM-1:0] MODE_RST = MODE_NUM'(1) << RESET_MODE;
  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_ARG} state_t;
  state_t state, state_n;
  logic rx_done_d, byte_ev, to_exp, sel_ok, mode_ok, step_ok, frame_ok, valid_n, err_n;
  logic [7:0] cmd, arg, cmd_n, arg_n, err_cnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SLOT_W-1:0] slot_n, step_slot;
  logic [MODE_NUM-1:0] mode_n;
  assign byte_ev = rx_done & ~rx_done_d;
  // cnt is cycles since the last byte minus one, so the registered error lands TIMEOUT_CYC cycles after it
  assign to_exp = state != IDLE && cnt == CW'(TIMEOUT_CYC - 2);
  assign sel_ok = cmd == 8'h01 && 32'(arg) < SLOT_NUM;
  assign mode_ok = cmd == 8'h02 && 32'(arg) < MODE_NUM;
  assign step_ok = cmd == 8'h03 && arg[7:1] == 7'd0;
  assign frame_ok = rx_data == (cmd ^ arg) && (sel_ok || mode_ok || step_ok);
  assign step_slot = arg[0] ? (slot_no == '0 ? (WRAP != 0 ? SLOT_MAX : slot_no) : slot_no - 1'b1)
                            : (slot_no == SLOT_MAX ? (WRAP != 0 ? '0 : slot_no) : slot_no + 1'b1);
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    arg_n = arg;
    slot_n = slot_no;
    mode_n = mode_onehot;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (byte_ev) begin
      case (state)
        IDLE: state_n = rx_data == 8'h55 ? GOT_HDR : IDLE;
        GOT_HDR: begin
          cmd_n = rx_data;
          state_n = GOT_CMD;
        end
        GOT_CMD: begin
          arg_n = rx_data;
          state_n = GOT_ARG;
        end
        default: begin
          state_n = IDLE;
          valid_n = frame_ok;
          err_n = ~frame_ok;
          slot_n = !frame_ok ? slot_no : sel_ok ? arg[SLOT_W-1:0] : step_ok ? step_slot : slot_no;
          mode_n = frame_ok && mode_ok ? MODE_NUM'(1) << arg : mode_onehot;
        end
      endcase
    end else if (to_exp) begin
      state_n = IDLE;
      err_n = 1'b1;
    end
    err_cnt_n = err_n && err_cnt != 8'hff ? err_cnt + 1'b1 : err_cnt;
    cnt_n = byte_ev || state_n == IDLE ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      rx_done_d <= 1'b0;
      cnt <= '0;
      cmd <= '0;
      arg <= '0;
      slot_no <= '0;
      mode_onehot <= MODE_RST;
      cmd_valid <= 1'b0;
      cmd_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      rx_done_d <= rx_done;
      cnt <= cnt_n;
      cmd <= cmd_n;
      arg <= arg_n;
      slot_no <= slot_n;
      mode_onehot <= mode_n;
      cmd_valid <= valid_n;
      cmd_err <= err_n;
      err_cnt <= err_cnt_n;
    end
  end
endmodule

// File: tb/tb_bt_cmd_frame_decoder.sv
// tb_bt_cmd_frame_decoder: random and directed frames against a byte-level command model, two parameter sets
module tb_bt_cmd_frame_decoder;
  localparam int TO = 100;
  logic sys_clk = 1'b0;
  logic sys_rst_n, rx_done;
  logic [7:0] rx_data;
  logic [3:0] mode_a, mode_b, slot_a, slot_b;
  logic valid_a, valid_b, err_a, err_b;
  logic [7:0] ecnt_a, ecnt_b;
  int checks = 0, errors = 0, cyc = 0;
  string phase = "reset";
  int snum[2] = '{16, 10};
  int wrap[2] = '{0, 1};
  int slot[2], mode[2], ecnt[2];
  logic ev[2], ee[2];
  logic [7:0] fb[4];
  int fn = 0, last_edge = 0;
  logic prev = 1'b0;
  always #5 sys_clk = ~sys_clk;
  bt_cmd_frame_decoder #(.TIMEOUT_CYC(TO)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .mode_onehot(mode_a), .slot_no(slot_a), .cmd_valid(valid_a), .cmd_err(err_a), .err_cnt(ecnt_a)
  );
  bt_cmd_frame_decoder #(.SLOT_NUM(10), .WRAP(1), .TIMEOUT_CYC(TO)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .mode_onehot(mode_b), .slot_no(slot_b), .cmd_valid(valid_b), .cmd_err(err_b), .err_cnt(ecnt_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic reject(input int i);
    ee[i] = 1'b1;
    if (ecnt[i] < 255) ecnt[i]++;
  endtask
  task automatic execute(input int i, input int c, input int a, input int k);
    bit ok = 1'b1;
    if (k != (c ^ a)) ok = 1'b0;
    else if (c == 1 && a < snum[i]) slot[i] = a;
    else if (c == 2 && a < 4) mode[i] = a;
    else if (c == 3 && a == 0) slot[i] = wrap[i] != 0 ? (slot[i] + 1) % snum[i] : (slot[i] + 1 < snum[i] ? slot[i] + 1 : slot[i]);
    else if (c == 3 && a == 1) slot[i] = wrap[i] != 0 ? (slot[i] + snum[i] - 1) % snum[i] : (slot[i] > 0 ? slot[i] - 1 : 0);
    else ok = 1'b0;
    if (ok) ev[i] = 1'b1;
    else reject(i);
  endtask
  task automatic model_update();
    logic edge_seen;
    ev = '{1'b0, 1'b0};
    ee = '{1'b0, 1'b0};
    edge_seen = rx_done && !prev;
    if (!sys_rst_n) begin
      prev = 1'b0;
      fn = 0;
      for (int i = 0; i < 2; i++) begin
        slot[i] = 0;
        mode[i] = 3;
        ecnt[i] = 0;
      end
    end else begin
      prev = rx_done;
      if (edge_seen) begin
        last_edge = cyc;
        if (fn == 0) fn = rx_data == 8'h55 ? 1 : 0;
        else begin
          fb[fn] = rx_data;
          fn++;
          if (fn == 4) begin
            for (int i = 0; i < 2; i++) execute(i, int'(fb[1]), int'(fb[2]), int'(fb[3]));
            fn = 0;
          end
        end
      end else if (fn != 0 && cyc + 1 - last_edge == TO) begin
        fn = 0;
        for (int i = 0; i < 2; i++) reject(i);
      end
    end
    cyc++;
  endtask
  function automatic logic [17:0] expect_vec(input int i);
    return {ev[i], ee[i], 8'(ecnt[i]), 4'(slot[i]), 4'(1 << mode[i])};
  endfunction
  task automatic step();
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    check({phase, "/a"}, 32'({valid_a, err_a, ecnt_a, slot_a, mode_a}), 32'(expect_vec(0)));
    check({phase, "/b"}, 32'({valid_b, err_b, ecnt_b, slot_b, mode_b}), 32'(expect_vec(1)));
  endtask
  task automatic idle(input int n);
    rx_done = 1'b0;
    repeat (n) step();
  endtask
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) step();
    rx_done = 1'b0;
    repeat (gap) begin
      rx_data = 8'($urandom);
      step();
    end
  endtask
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input bit jit);
    logic [7:0] fr[4];
    fr = '{8'h55, c, a, k};
    for (int j = 0; j < 4; j++)
      send_byte(fr[j], jit ? int'($urandom_range(1, 3)) : 1, jit ? int'($urandom_range(1, 4)) : 1);
  endtask
  initial begin
    int r;
    logic [7:0] c, a, k;
    sys_rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) step();
    sys_rst_n = 1'b1;
    idle(2);
    phase = "sel_slot";    send_frame(8'h01, 8'h07, 8'h06, 1'b0);
    phase = "set_mode";    send_frame(8'h02, 8'h01, 8'h03, 1'b0);
    phase = "bad_chk";     send_frame(8'h01, 8'h05, 8'h00, 1'b0);
    phase = "bad_mode";    send_frame(8'h02, 8'h09, 8'h0b, 1'b0);
    phase = "slot15";      send_frame(8'h01, 8'h0f, 8'h0e, 1'b0);
    phase = "step_hi";     send_frame(8'h03, 8'h00, 8'h03, 1'b0);
    phase = "slot0";       send_frame(8'h01, 8'h00, 8'h01, 1'b0);
    phase = "step_lo";     send_frame(8'h03, 8'h01, 8'h02, 1'b0);
    phase = "timeout";     send_byte(8'h55, 1, 1); send_byte(8'h01, 1, 1); idle(110);
    phase = "after_to";    send_frame(8'h01, 8'h03, 8'h02, 1'b0);
    phase = "collide_99";  send_byte(8'h55, 1, 98); send_byte(8'h01, 1, 1); send_byte(8'h04, 1, 1); send_byte(8'h05, 1, 3);
    phase = "collide_100"; send_byte(8'h55, 1, 99); send_byte(8'h01, 1, 1); send_frame(8'h01, 8'h06, 8'h07, 1'b0);
    phase = "held";        send_byte(8'h55, 20, 1); send_byte(8'h01, 1, 1); send_byte(8'h08, 1, 1); send_byte(8'h09, 1, 2);
    phase = "rst_mid";     send_byte(8'h55, 1, 1); send_byte(8'h01, 1, 1);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    send_frame(8'h01, 8'h02, 8'h03, 1'b0);
    for (int n = 0; n < 300; n++) begin
      phase = "random";
      r = int'($urandom_range(0, 9));
      if (r == 0) send_byte(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      else if (r == 1) begin
        send_byte(8'h55, 1, 1);
        send_byte(8'($urandom_range(1, 3)), 1, int'($urandom_range(95, 105)));
      end else if (r == 2) begin
        send_byte(8'h55, 1, 1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
      end else begin
        c = 8'($urandom_range(0, 4));
        a = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 17));
        k = c ^ a;
        if ($urandom_range(0, 5) == 0) k = k ^ 8'h10;
        send_frame(c, a, k, 1'b1);
      end
    end
    phase = "err_sat";
    repeat (260) send_frame(8'h01, 8'h00, 8'hff, 1'b0);
    send_frame(8'h01, 8'h05, 8'h04, 1'b0);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bt_cmd_frame_decoder.md
# bt_cmd_frame_decoder

Parametrised successor to the Bluetooth single-byte mode controller. It sits between `uart_recv` and the camera datapath. It parses framed, checksummed 4-byte commands from the Bluetooth UART and drives three outputs: a one-hot operating-mode vector, the selected photo-slot index, and command status pulses. Compared with the earlier controller it adds:

- configurable slot and mode counts,
- checksum validation,
- an inter-byte timeout,
- optional slot wrap-around,
- error reporting.

## Interface
Parameters:
- `SLOT_W`, 4 — width of the slot index.
- `SLOT_NUM`, 16 — number of valid slots; must satisfy 1 ≤ `SLOT_NUM` ≤ 2^`SLOT_W`.
- `MODE_NUM`, 4 — number of modes. Encoding: 0 idle, 1 get_photo, 2 caught_photo, 3 camera_show.
- `RESET_MODE`, 3 — mode index active after reset; must be < `MODE_NUM`.
- `WRAP`, 0 — 1 makes slot step commands wrap around; 0 makes them saturate.
- `TIMEOUT_CYC`, 1_000_000 — maximum number of idle cycles allowed between bytes within one frame.

Ports:
- `sys_clk` in 1 — system clock.
- `sys_rst_n` in 1 — reset, synchronous and active-low.
- `rx_done` in 1 — byte-ready flag from `uart_recv`; may be held high for several cycles.
- `rx_data` in 8 — received byte; stable while `rx_done` is high.
- `mode_onehot` out `MODE_NUM` — one-hot current mode; exactly one bit is set at all times.
- `slot_no` out `SLOT_W` — selected photo slot.
- `cmd_valid` out 1 — one-cycle pulse when a frame is accepted and executed.
- `cmd_err` out 1 — one-cycle pulse when a frame is rejected or times out.
- `err_cnt` out 8 — saturating count of rejected frames.

## Operation
- **Byte strobe.** `rx_done` is registered once. A byte event is `rx_done & ~rx_done_d`, and `rx_data` is sampled in that same cycle.
- **Frame format.** Bytes arrive in order: `HDR`=0x55, `CMD`, `ARG`, `CHK`. A frame is valid only if `CHK` == `CMD` ^ `ARG`.
- **FSM states:** `IDLE`, `GOT_HDR`, `GOT_CMD`, `GOT_ARG`.
  - `IDLE`: on a byte, go to `GOT_HDR` if the byte is 0x55; otherwise discard it silently (no error).
  - `GOT_HDR`: on a byte, latch `CMD` and go to `GOT_CMD`. A byte of value 0x55 here is treated as `CMD`; there is no resync.
  - `GOT_CMD`: on a byte, latch `ARG` and go to `GOT_ARG`.
  - `GOT_ARG`: on a byte, evaluate the frame and return to `IDLE`.
- **Commands** (executed only when the checksum passes):
  - 0x01 select slot: if `ARG` < `SLOT_NUM`, then `slot_no` ← `ARG[SLOT_W-1:0]`; otherwise error.
  - 0x02 set mode: if `ARG` < `MODE_NUM`, then `mode_onehot` ← 1<<`ARG`; otherwise error.
  - 0x03 step slot:
    - `ARG`=0x00 increments `slot_no`. At `SLOT_NUM`-1 it holds when `WRAP`=0 and goes to 0 when `WRAP`=1.
    - `ARG`=0x01 decrements `slot_no`. At 0 it holds when `WRAP`=0 and goes to `SLOT_NUM`-1 when `WRAP`=1.
    - Any other `ARG` is an error.
    - A saturated (held) step still counts as valid.
  - Any other `CMD`: error.
- **Error handling.** On a checksum failure, bad command or bad argument: no state change, `cmd_err` pulses, and `err_cnt` increments, saturating at 255.
- **Timeout.** A counter clears on every byte event and counts while the FSM is not in `IDLE`. When it reaches `TIMEOUT_CYC`-1, the FSM returns to `IDLE`, `cmd_err` pulses and `err_cnt` increments. The counter is held at 0 while in `IDLE`.
- **Reset values:**
  - `mode_onehot` = 1<<`RESET_MODE`
  - `slot_no` = 0
  - `cmd_valid` = 0, `cmd_err` = 0
  - `err_cnt` = 0
  - FSM in `IDLE`, timeout counter = 0, `rx_done_d` = 0
  - A reset in mid-frame discards the partial frame without raising an error.

## Timing
- **Latency.** Let T be the cycle in which the `CHK` byte edge is detected.
  - `slot_no` and `mode_onehot` hold their new values from T+1.
  - `cmd_valid` or `cmd_err` is high for exactly cycle T+1.
- **Timeout.** `cmd_err` is high exactly `TIMEOUT_CYC` cycles after the last byte edge.
- **Byte/timeout collision.** If a byte edge and timeout expiry fall in the same cycle, the byte wins: it is processed and the counter clears.
- **Pulse exclusivity.** `cmd_valid` and `cmd_err` are never high in the same cycle.
- **Byte rate.** The block accepts a new byte edge every 2 cycles minimum.
- **No held strobe.** `rx_done` held high produces only one byte event.

## Test plan
- **Reset state.** Reset with defaults → `mode_onehot`=4'b1000, `slot_no`=0, `err_cnt`=0.
- **Select slot.** Send 55 01 07 06 → `slot_no`=7 and a single-cycle `cmd_valid` at T+1. Then send 55 02 01 03 → `mode_onehot`=4'b0010.
- **Checksum error.** Send 55 01 05 00 → `slot_no` unchanged, `cmd_err` pulses once, `err_cnt`=1. Then send 55 02 09 0B → bad mode, `err_cnt`=2.
- **Step saturation/wrap.**
  - `WRAP`=0, `slot_no`=15: send 55 03 00 03 → `slot_no` stays 15 and `cmd_valid` pulses.
  - `WRAP`=1, `SLOT_NUM`=10, `slot_no`=0: send 55 03 01 02 → `slot_no`=9.
- **Timeout.** `TIMEOUT_CYC`=100: send 55 01, then idle for 100 cycles → `cmd_err` fires 100 cycles after the 01 edge. Then send 55 01 03 02 → `slot_no`=3.
- **Strobe and reset corner cases.**
  - Hold `rx_done` high for 20 cycles on byte 55 → counted as a single byte.
  - Assert `sys_rst_n`=0 after 55 01 → the next frame 55 01 02 03 is accepted normally with no error.
